// File: rtl/target_frame_encode_pkg.sv
// Shared widths, FSM encoding, frame configuration record and LFSR constants
// for the target frame encoder.
package target_frame_encode_pkg;

  localparam int          FRAME_LEN_DEF = 1024;
  localparam int          ADDR_W        = 10;
  localparam int          DENS_W        = 8;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] tgt_start;
    logic [ADDR_W-1:0] tgt_end;
    logic [DENS_W-1:0] dens_tgt;
    logic [DENS_W-1:0] dens_bg;
  } cfg_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/target_frame_encode_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left; reset and load both restore the seed,
// load wins over step.
module frame_lfsr16
  import target_frame_encode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_q <= seed;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/target_frame_encode.sv
// Serial frame generator: one bit per synclk strobe, registered (valid one clk after strobe).
// TGT_ENC_DETERMINISTIC_EN: bits = in-target-region, no LFSR, densities ignored.
module target_frame_encode
  import target_frame_encode_pkg::*;
#(
  parameter int          FRAME_LEN = FRAME_LEN_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              synclk,
  input  logic [ADDR_W-1:0] tgt_start_addr,
  input  logic [ADDR_W-1:0] tgt_end_addr,
  input  logic [DENS_W-1:0] dens_tgt,
  input  logic [DENS_W-1:0] dens_bg,
  output logic              bits,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  cfg_t              r_cfg;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_bits;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic w_accept;
  logic w_strobe;
  logic w_in_region;
  logic w_bit;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_strobe = (r_state == ST_RUN) && synclk;
  // Counter never passes FRAME_LEN-1, so an oversized end clips on its own and
  // start > end can never match.
  assign w_in_region = (r_cnt >= r_cfg.tgt_start) && (r_cnt <= r_cfg.tgt_end);

`ifdef TGT_ENC_DETERMINISTIC_EN
  logic w_unused_dens;
  assign w_unused_dens = ^{r_cfg.dens_tgt, r_cfg.dens_bg};
  assign w_bit         = w_in_region;
`else
  logic [15:0]       w_lfsr_q;
  logic [DENS_W-1:0] w_dens;
  logic              w_unused_lfsr_hi;

  frame_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (w_accept),
    .step  (w_strobe),
    .seed  (LFSR_SEED),
    .q     (w_lfsr_q)
  );

  assign w_unused_lfsr_hi = ^w_lfsr_q[15:8];
  assign w_dens = w_in_region ? r_cfg.dens_tgt : r_cfg.dens_bg;
  assign w_bit  = (w_dens == 8'hFF) || (w_lfsr_q[7:0] < w_dens);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_RUN;
      ST_RUN:    if (w_strobe && (r_cnt == LAST_ADDR)) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg   <= '0;
      r_cnt   <= '0;
      r_bits  <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_strobe;
      r_done  <= (r_state == ST_FINISH);
      if (w_accept) begin
        r_cfg <= '{tgt_start: tgt_start_addr, tgt_end: tgt_end_addr,
                   dens_tgt: dens_tgt, dens_bg: dens_bg};
        r_cnt <= '0;
      end
      if (w_strobe) begin
        r_bits <= w_bit;
        r_addr <= r_cnt;
        r_cnt  <= r_cnt + 1'b1;
      end
      // busy falls the cycle after done unless a back-to-back start arrives then
      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
    end
  end

  assign bits  = r_bits;
  assign addr  = r_addr;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_target_frame_encode.sv
// Directed bench: table of frame configurations against a bit-level reference,
// plus hand sequences for reset abort, start collisions and a 2-bit frame.
module tb_target_frame_encode;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, synclk = 1'b0;
  logic [9:0] ts = '0, te = '0;
  logic [7:0] dt = '0, db = '0;
  logic       bits, valid, busy, done;
  logic [9:0] addr;

  logic       start2 = 1'b0, synclk2 = 1'b0;
  logic [9:0] ts2 = '0, te2 = '0;
  logic [7:0] dt2 = '0, db2 = '0;
  logic       bits2, valid2, busy2, done2;
  logic [9:0] addr2;

  target_frame_encode #(.FRAME_LEN(1024), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .synclk(synclk),
    .tgt_start_addr(ts), .tgt_end_addr(te), .dens_tgt(dt), .dens_bg(db),
    .bits(bits), .addr(addr), .valid(valid), .busy(busy), .done(done));

  target_frame_encode #(.FRAME_LEN(2), .LFSR_SEED(SEED)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .synclk(synclk2),
    .tgt_start_addr(ts2), .tgt_end_addr(te2), .dens_tgt(dt2), .dens_bg(db2),
    .bits(bits2), .addr(addr2), .valid(valid2), .busy(busy2), .done(done2));

  typedef struct {
    logic [9:0] ts, te;
    logic [7:0] dt, db;
    int         gap;
    int         exp_ones;    // -1: rely on the per-bit reference only
    bit         extra_start;
    bit         mid_change;
  } vec_t;

  vec_t vecs[6];
  int   tests = 0, failed = 0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic ref_bit(input int a, input logic [15:0] l, input vec_t c);
    logic       in_rgn;
    logic [7:0] d;
    in_rgn = (a >= int'(c.ts)) && (a <= int'(c.te));
`ifdef TGT_ENC_DETERMINISTIC_EN
    d = l[7:0];
    return in_rgn && (d == d);
`else
    d = in_rgn ? c.dt : c.db;
    if (d == 8'hFF) return 1'b1;
    return l[7:0] < d;
`endif
  endfunction

  // Passive monitor on the full-size instance
  vec_t        m_cfg;
  logic [15:0] m_lfsr;
  int m_addr, m_mism, m_addr_err, m_ones, m_nvalid, m_ndone;
  int m_last_valid, m_done_cyc, m_busy_at_done, m_busy_after_done;
  logic m_done_prev = 1'b0;

  always @(negedge clk) begin
    if (m_done_prev) m_busy_after_done = int'(busy);
    m_done_prev = done;
    if (valid) begin
      if (addr != m_addr[9:0]) m_addr_err++;
      if (bits != ref_bit(m_addr, m_lfsr, m_cfg)) m_mism++;
      if (bits) m_ones++;
      m_lfsr = ref_step(m_lfsr);
      m_addr++;
      m_nvalid++;
      m_last_valid = cyc;
    end
    if (done) begin
      m_ndone++;
      m_done_cyc = cyc;
      m_busy_at_done = int'(busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int abort_at);
    m_cfg = v; m_lfsr = SEED; m_addr = 0; m_mism = 0; m_addr_err = 0;
    m_ones = 0; m_nvalid = 0; m_ndone = 0; m_last_valid = -100; m_done_cyc = -1;
    m_busy_at_done = -1; m_busy_after_done = -1;
    ts = v.ts; te = v.te; dt = v.dt; db = v.db;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 1024; i++) begin
      if (v.extra_start && i == 300) start = 1'b1;
      if (v.mid_change && i == 500) begin
        ts = 10'd0; te = 10'd1023; dt = 8'h00; db = 8'hFF;
      end
      synclk = 1'b1;
      tick();
      synclk = 1'b0;
      start  = 1'b0;
      if (i == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy",  int'(busy),  0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_addr",  int'(addr),  0);
        chk("abort_bits",  int'(bits),  0);
        repeat (20) tick();
        chk("abort_no_done", m_ndone, 0);
        return;
      end
      if (i == 1023 && v.extra_start) start = 1'b1;  // lands in FINISH
      repeat (v.gap - 1) begin
        tick();
        start = 1'b0;
      end
    end
    for (int k = 0; k < 8 && m_ndone == 0; k++) tick();
    repeat (4) tick();
    chk("frame_valids",   m_nvalid, 1024);
    chk("frame_addr_seq", m_addr_err, 0);
    chk("frame_bits",     m_mism, 0);
    chk("frame_dones",    m_ndone, 1);
    chk("done_latency",   m_done_cyc - m_last_valid, 1);
    chk("busy_at_done",   m_busy_at_done, 1);
    chk("busy_after_done", m_busy_after_done, 0);
    if (v.exp_ones >= 0) chk("frame_ones", m_ones, v.exp_ones);
  endtask

  initial begin
    vecs[0] = '{ts: 10'd0,   te: 10'd1023, dt: 8'hFF, db: 8'h00, gap: 2, exp_ones: 1024, extra_start: 0, mid_change: 0};
    vecs[1] = '{ts: 10'd0,   te: 10'd1023, dt: 8'h00, db: 8'hFF, gap: 2, exp_ones: 0,    extra_start: 0, mid_change: 0};
    vecs[2] = '{ts: 10'd500, te: 10'd10,   dt: 8'hFF, db: 8'h80, gap: 2, exp_ones: -1,   extra_start: 0, mid_change: 0};
    vecs[3] = '{ts: 10'd100, te: 10'd199,  dt: 8'hFF, db: 8'h00, gap: 4, exp_ones: 100,  extra_start: 1, mid_change: 1};
    vecs[4] = '{ts: 10'd200, te: 10'd200,  dt: 8'hFF, db: 8'h00, gap: 2, exp_ones: 1,    extra_start: 0, mid_change: 0};
    vecs[5] = '{ts: 10'd0,   te: 10'd511,  dt: 8'h40, db: 8'hC0, gap: 2, exp_ones: -1,   extra_start: 0, mid_change: 0};
`ifdef TGT_ENC_DETERMINISTIC_EN
    vecs[1].exp_ones = 1024;
    vecs[2].exp_ones = 0;
    vecs[5].exp_ones = 512;
`endif

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_bits",  int'(bits),  0);
    chk("rst_addr",  int'(addr),  0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_busy2", int'(busy2), 0);

    for (int n = 0; n < 6; n++) run_frame(vecs[n], -1);

    // synclk while idle must not produce output
    for (int k = 0; k < 3; k++) begin
      synclk = 1'b1; tick(); synclk = 1'b0; tick();
    end
    chk("idle_synclk_valids", m_nvalid, 1024);

    // Abort at addr 700, then the identical frame must replay from addr 0
    run_frame(vecs[2], 700);
    run_frame(vecs[2], -1);

    // Two-bit frame: start+synclk collision, clipped region 1..5, back-to-back
    ts2 = 10'd1; te2 = 10'd5; dt2 = 8'hFF; db2 = 8'h00;
    start2 = 1'b1; synclk2 = 1'b1;
    tick();
    start2 = 1'b0; synclk2 = 1'b0;
    chk("f2_collide_valid", int'(valid2), 0);
    chk("f2_busy", int'(busy2), 1);
    tick();
    chk("f2_no_spurious_valid", int'(valid2), 0);
    synclk2 = 1'b1; tick(); synclk2 = 1'b0;
    chk("f2_v0_valid", int'(valid2), 1);
    chk("f2_v0_addr",  int'(addr2),  0);
    chk("f2_v0_bits",  int'(bits2),  0);
    tick();
    chk("f2_pulse_len", int'(valid2), 0);
    synclk2 = 1'b1; tick(); synclk2 = 1'b0;
    chk("f2_v1_addr", int'(addr2), 1);
    chk("f2_v1_bits", int'(bits2), 1);
    chk("f2_v1_no_done", int'(done2), 0);
    tick();
    chk("f2_done", int'(done2), 1);
    chk("f2_busy_at_done", int'(busy2), 1);
    chk("f2_hold_addr", int'(addr2), 1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("f2_done_pulse", int'(done2), 0);
    chk("f2_b2b_busy", int'(busy2), 1);
    synclk2 = 1'b1; tick(); synclk2 = 1'b0;
    chk("f2_b2b_addr0", int'(addr2), 0);
    tick();
    synclk2 = 1'b1; tick(); synclk2 = 1'b0;
    chk("f2_b2b_addr1", int'(addr2), 1);
    tick();
    chk("f2_b2b_done", int'(done2), 1);
    tick();
    chk("f2_idle_busy", int'(busy2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
